pipelined_add_sub: RTL and testbench



---
 rtl/pipelined_add_sub_pkg.sv | 20 ++
 rtl/pipelined_add_sub_if.sv | 31 +++
 rtl/pipelined_add_sub_seg_adder.sv | 31 +++
 rtl/pipelined_add_sub.sv | 124 ++++++++++++
 tb/tb_pipelined_add_sub.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_add_sub_pkg.sv
// Shared sizing helpers for the segmented pipelined adder/subtractor.
// Every segment is SEG bits wide. Segment k covers bits segLo(k) up to segHi(k).
package pipelined_add_sub_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SEG   = 4;

    function automatic int calcNseg(input int width, input int seg);
        return width / seg;
    endfunction

    function automatic int segLo(input int k, input int seg);
        return k * seg;
    endfunction

    function automatic int segHi(input int k, input int seg);
        return k * seg + seg - 1;
    endfunction

endpackage

// File: rtl/pipelined_add_sub_if.sv
// Operand/result bus with valid/ready handshakes on both sides.
// The producer and consumer use the master modport. The adder uses the slave modport.
interface pipelined_add_sub_if
    import pipelined_add_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    modport master (
        output in_valid, A, B, Cin, sub, out_ready,
        input  in_ready, out_valid, Sum, Cout, Ovf
    );

    modport slave (
        input  in_valid, A, B, Cin, sub, out_ready,
        output in_ready, out_valid, Sum, Cout, Ovf
    );

endinterface

// File: rtl/pipelined_add_sub_seg_adder.sv
// Combinational SEG-bit ripple adder for one pipeline segment.
// It also exposes the carry into its top bit, which the top segment needs to compute signed overflow.
module seg_adder
    import pipelined_add_sub_pkg::*;
#(
    parameter int SEG = DEF_SEG
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb_in
);

    logic [SEG:0] w_carry;

    always_comb begin
        w_carry    = '0;
        s          = '0;
        w_carry[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            s[i]           = a[i] ^ b[i] ^ w_carry[i];
            w_carry[i + 1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
        end
    end

    assign co       = w_carry[SEG];
    assign c_msb_in = w_carry[SEG-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined add/subtract: operands are captured, then one SEG-bit segment is resolved per stage.
// Carries are registered between stages, and a single global stall freezes the whole pipe (NSEG >= 2).
module pipelined_add_sub
    import pipelined_add_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input logic clk,
    input logic rst,
    pipelined_add_sub_if.slave bus
);

    localparam int NSEG = calcNseg(WIDTH, SEG);
    localparam int REMW = WIDTH - SEG;

    logic             w_stall;
    logic [WIDTH-1:0] w_bop;
    logic             w_c0;

    // r_valid[0] belongs to the operand capture register; r_valid[k+1] belongs to segment stage k.
    logic [NSEG:0]    r_valid;
    logic [WIDTH-1:0] r_inA;
    logic [WIDTH-1:0] r_inB;
    logic             r_inC;
    logic [REMW-1:0]  r_aRem [NSEG-1];
    logic [REMW-1:0]  r_bRem [NSEG-1];
    logic [WIDTH-1:0] r_sum  [NSEG];
    logic [NSEG-1:0]  r_carry;
    logic             r_ovf;

    logic [SEG-1:0]   w_segA [NSEG];
    logic [SEG-1:0]   w_segB [NSEG];
    logic [SEG-1:0]   w_segS [NSEG];
    logic [NSEG-1:0]  w_segCi;
    logic [NSEG-1:0]  w_segCo;
    logic             w_cMsbTop;

    assign w_stall = r_valid[NSEG] && !bus.out_ready;
    assign w_bop   = bus.sub ? ~bus.B : bus.B;
    assign w_c0    = bus.sub ? 1'b1 : bus.Cin;
    assign w_segCi = {r_carry[NSEG-2:0], r_inC};

    // Each stage consumes the lowest remaining operand segment that travels along with its beat.
    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            w_segA[k] = '0;
            w_segB[k] = '0;
        end
        w_segA[0] = r_inA[segLo(0, SEG) +: SEG];
        w_segB[0] = r_inB[segLo(0, SEG) +: SEG];
        for (int k = 1; k < NSEG; k++) begin
            w_segA[k] = r_aRem[k-1][SEG-1:0];
            w_segB[k] = r_bRem[k-1][SEG-1:0];
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        if (k == NSEG - 1) begin : g_top
            seg_adder #(.SEG(SEG)) u_add (
                .a        (w_segA[k]),
                .b        (w_segB[k]),
                .ci       (w_segCi[k]),
                .s        (w_segS[k]),
                .co       (w_segCo[k]),
                .c_msb_in (w_cMsbTop)
            );
        end else begin : g_low
            logic w_unusedCmsb;
            seg_adder #(.SEG(SEG)) u_add (
                .a        (w_segA[k]),
                .b        (w_segB[k]),
                .ci       (w_segCi[k]),
                .s        (w_segS[k]),
                .co       (w_segCo[k]),
                .c_msb_in (w_unusedCmsb)
            );
        end
    end

    // Lower sum segments ride forward in r_sum so that the last stage presents an aligned word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_inA   <= '0;
            r_inB   <= '0;
            r_inC   <= 1'b0;
            r_carry <= '0;
            r_ovf   <= 1'b0;
            for (int k = 0; k < NSEG; k++) begin
                r_sum[k] <= '0;
            end
            for (int k = 0; k < NSEG - 1; k++) begin
                r_aRem[k] <= '0;
                r_bRem[k] <= '0;
            end
        end else if (!w_stall) begin
            r_valid   <= {r_valid[NSEG-1:0], bus.in_valid};
            r_inA     <= bus.A;
            r_inB     <= w_bop;
            r_inC     <= w_c0;
            r_carry   <= w_segCo;
            r_ovf     <= w_cMsbTop ^ w_segCo[NSEG-1];
            r_sum[0]  <= {{REMW{1'b0}}, w_segS[0]};
            r_aRem[0] <= r_inA[WIDTH-1:SEG];
            r_bRem[0] <= r_inB[WIDTH-1:SEG];
            for (int k = 1; k < NSEG; k++) begin
                r_sum[k]                      <= r_sum[k-1];
                r_sum[k][segLo(k, SEG) +: SEG] <= w_segS[k];
            end
            for (int k = 1; k < NSEG - 1; k++) begin
                r_aRem[k] <= r_aRem[k-1] >> SEG;
                r_bRem[k] <= r_bRem[k-1] >> SEG;
            end
        end
    end

    assign bus.in_ready  = !w_stall;
    assign bus.out_valid = r_valid[NSEG];
    assign bus.Sum       = r_sum[NSEG-1];
    assign bus.Cout      = r_carry[NSEG-1];
    assign bus.Ovf       = r_ovf;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub (WIDTH=16, SEG=4): table vectors, directed flow/reset sequences and random traffic.
// Results are scored against an arithmetic reference model with a timing model based on stall-adjusted age.
module tb_pipelined_add_sub;

    localparam int WIDTH = 16;
    localparam int LAT   = 4;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          acceptEdge;
        int          stallBase;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] expSum;
        logic        expCout;
        logic        expOvf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    pipelined_add_sub_if #(.WIDTH(WIDTH)) bus ();

    pipelined_add_sub #(.WIDTH(WIDTH), .SEG(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    logic [15:0] gotSums[$];
    int          total = 0;
    int          bad = 0;
    int          edgeCount = 0;
    int          stallCount = 0;
    bit          lastAccepted;
    bit          lastEmitted;
    logic [15:0] lastSum;
    logic        lastCout;
    logic        lastOvf;
    vec_t        vecs[10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic reportFail(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s actual=timeout required=completion", name);
    endtask

    // The reference arithmetic is exact integer math. Overflow means the true signed result falls outside the 16-bit range.
    function automatic exp_t refModel(input logic [15:0] a, input logic [15:0] b,
                                      input logic cin, input logic sub);
        exp_t        r;
        int unsigned ua;
        int unsigned ub;
        int unsigned full;
        int          sa;
        int          sbv;
        int          sres;
        ua  = 32'(a);
        ub  = 32'(b);
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        if (sub) begin
            full   = ua - ub;
            r.cout = (ua >= ub);
            sres   = sa - sbv;
        end else begin
            full   = ua + ub + 32'(cin);
            r.cout = (full > 32'd65535);
            sres   = sa + sbv + int'(cin);
        end
        r.sum        = full[15:0];
        r.ovf        = (sres > 32767) || (sres < -32768);
        r.acceptEdge = 0;
        r.stallBase  = 0;
        return r;
    endfunction

    task automatic applyStimulus(input logic valid, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
        bus.in_valid = valid;
        bus.A        = a;
        bus.B        = b;
        bus.Cin      = cin;
        bus.sub      = sub;
    endtask

    // Each call observes one clock cycle away from the edge.
    // It checks handshakes and data against the model, then steps to just after the next rising edge.
    task automatic cycle();
        exp_t e;
        bit   modelValid;
        bit   modelStall;
        @(negedge clk);
        lastAccepted = 1'b0;
        lastEmitted  = 1'b0;
        modelValid = (sb.size() > 0) &&
                     ((edgeCount - sb[0].acceptEdge - (stallCount - sb[0].stallBase)) >= LAT);
        modelStall = modelValid && !bus.out_ready;
        checkOutput("outValid", 32'(bus.out_valid), 32'(modelValid));
        checkOutput("inReady", 32'(bus.in_ready), 32'(!modelStall));
        if (modelValid) begin
            checkOutput("sum", 32'(bus.Sum), 32'(sb[0].sum));
            checkOutput("cout", 32'(bus.Cout), 32'(sb[0].cout));
            checkOutput("ovf", 32'(bus.Ovf), 32'(sb[0].ovf));
            if (bus.out_ready) begin
                void'(sb.pop_front());
                lastEmitted = 1'b1;
                lastSum     = bus.Sum;
                lastCout    = bus.Cout;
                lastOvf     = bus.Ovf;
                gotSums.push_back(bus.Sum);
            end
        end
        if (bus.in_valid && !modelStall) begin
            e            = refModel(bus.A, bus.B, bus.Cin, bus.sub);
            e.acceptEdge = edgeCount + 1;
            e.stallBase  = stallCount;
            sb.push_back(e);
            lastAccepted = 1'b1;
        end
        @(posedge clk);
        edgeCount++;
        if (modelStall) stallCount++;
        #1;
    endtask

    // Reset is asserted between clock edges, so the outputs must clear without waiting for a clock edge.
    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        #2;
        checkOutput("rstOutValid", 32'(bus.out_valid), 0);
        checkOutput("rstSum", 32'(bus.Sum), 0);
        checkOutput("rstCout", 32'(bus.Cout), 0);
        checkOutput("rstOvf", 32'(bus.Ovf), 0);
        sb.delete();
        @(posedge clk);
        edgeCount++;
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rstInReady", 32'(bus.in_ready), 1);
    endtask

    task automatic waitEmit(input string name);
        for (int n = 0; n < 15 && !lastEmitted; n++) cycle();
        if (!lastEmitted) reportFail(name);
    endtask

    function automatic logic [15:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int idx;
        int dropLeft;
        bit dropped;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[9] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

        bus.out_ready = 1'b1;
        doReset();

        $display("[TB] directed vector table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            cycle();
            applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
            waitEmit("vecTimeout");
            checkOutput("vecSum", 32'(lastSum), 32'(vecs[i].expSum));
            checkOutput("vecCout", 32'(lastCout), 32'(vecs[i].expCout));
            checkOutput("vecOvf", 32'(lastOvf), 32'(vecs[i].expOvf));
        end

        $display("[TB] back-to-back stream");
        gotSums.delete();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 16'(i), 16'(3 * i), 1'b0, 1'b0);
            #1;
            checkOutput("b2bInReady", 32'(bus.in_ready), 1);
            cycle();
        end
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        for (int n = 0; n < 30 && sb.size() > 0; n++) cycle();
        checkOutput("b2bCount", 32'(gotSums.size()), 20);
        for (int i = 0; i < 20 && i < gotSums.size(); i++) begin
            checkOutput("b2bSum", 32'(gotSums[i]), 32'(4 * i));
        end

        $display("[TB] backpressure");
        gotSums.delete();
        idx = 0;
        dropLeft = 0;
        dropped = 1'b0;
        for (int n = 0; n < 60 && gotSums.size() < 6; n++) begin
            bus.out_ready = (dropLeft == 0);
            if (idx < 6) applyStimulus(1'b1, 16'h1000 + 16'(idx), 16'(idx), 1'b0, 1'b0);
            else applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
            #1;
            if (dropLeft > 0) checkOutput("bpInReady", 32'(bus.in_ready), 0);
            cycle();
            if (lastAccepted) idx++;
            if (dropLeft > 0) dropLeft--;
            if (!dropped && bus.out_valid) begin
                dropped = 1'b1;
                dropLeft = 3;
            end
        end
        bus.out_ready = 1'b1;
        checkOutput("bpCount", 32'(gotSums.size()), 6);
        for (int i = 0; i < 6 && i < gotSums.size(); i++) begin
            checkOutput("bpSum", 32'(gotSums[i]), 32'(16'h1000 + 16'(2 * i)));
        end

        $display("[TB] reset mid-flight");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'(i + 1), 16'h0001, 1'b0, 1'b0);
            cycle();
        end
        doReset();
        for (int n = 0; n < 8; n++) begin
            cycle();
            checkOutput("rstQuiet", 32'(bus.out_valid), 0);
        end
        applyStimulus(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        waitEmit("rstNextTimeout");
        checkOutput("rstNextSum", 32'(lastSum), 32'h0002);

        $display("[TB] reset while a result is stalled");
        applyStimulus(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        for (int n = 0; n < 10 && !bus.out_valid; n++) cycle();
        cycle();
        checkOutput("stalledValid", 32'(bus.out_valid), 1);
        checkOutput("stalledSum", 32'(bus.Sum), 32'h3333);
        doReset();
        bus.out_ready = 1'b1;

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), pickOperand(), pickOperand(),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            bus.out_ready = 1'($urandom_range(0, 3) != 0);
            cycle();
        end
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        for (int n = 0; n < 40 && sb.size() > 0; n++) cycle();
        if (sb.size() != 0) reportFail("drainTimeout");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
